// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiply-add unit among N_REQ requesters.
// Define MAC_SHARE_STATS_EN to add per-requester saturating grant counters (grant_count, stats_clr).
module mac_share_arbiter #(
  parameter int unsigned bus_width   = 8,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAC_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*bus_width-1:0]    req_a,
  input  logic [N_REQ*bus_width-1:0]    req_b,
  input  logic [N_REQ*bus_width-1:0]    req_c,
  output logic [bus_width-1:0]          mac_a,
  output logic [bus_width-1:0]          mac_b,
  output logic [bus_width-1:0]          mac_c,
  input  logic [2*bus_width-1:0]        mac_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [2*bus_width-1:0]        rsp_data,
  output logic                          busy
`ifdef MAC_SHARE_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [N_REQ*16-1:0]           grant_count
`endif
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned SW  = IDW + 1;
  localparam int unsigned RW  = 2 * bus_width;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]       ptr_q, ptr_d, gnt_idx;
  logic [SW-1:0]        sum;
  logic                 found, issue_ok, hs, pop, push;
  logic [CW-1:0]        out_q, out_d, fcnt_q, fcnt_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [bus_width-1:0] mac_a_q, mac_b_q, mac_c_q;
  logic [MAC_LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0]       tag_id_q [MAC_LATENCY];
  logic [IDW-1:0]       fid_q    [FIFO_DEPTH];
  logic [RW-1:0]        fdat_q   [FIFO_DEPTH];

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = SW'(ptr_q) + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[IDW-1:0];
      end
    end
  end

  // out_q counts results in flight plus buffered; a same-cycle pop frees a credit.
  always_comb begin
    pop       = rsp_valid && rsp_ready;
    push      = tag_vld_q[MAC_LATENCY-1];
    issue_ok  = (out_q < CW'(FIFO_DEPTH)) || pop;
    hs        = found && issue_ok;
    req_ready = hs ? (N_REQ'(1) << gnt_idx) : '0;
    ptr_d     = ptr_q;
    if (hs) ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    out_d     = out_q + CW'(hs) - CW'(pop);
    fcnt_d    = fcnt_q + CW'(push) - CW'(pop);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (push) wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (pop)  rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      out_q     <= '0;
      fcnt_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_c_q   <= '0;
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < MAC_LATENCY; s++) tag_id_q[s] <= '0;
      for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
        fid_q[e]  <= '0;
        fdat_q[e] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      out_q  <= out_d;
      fcnt_q <= fcnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      if (hs) begin
        mac_a_q <= req_a[gnt_idx*bus_width +: bus_width];
        mac_b_q <= req_b[gnt_idx*bus_width +: bus_width];
        mac_c_q <= req_c[gnt_idx*bus_width +: bus_width];
      end
      // Tag pipe tracks which requester owns the result emerging from the unit.
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= gnt_idx;
      for (int unsigned s = 1; s < MAC_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      if (push) begin
        fid_q[wr_q]  <= tag_id_q[MAC_LATENCY-1];
        fdat_q[wr_q] <= mac_result;
      end
    end
  end

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign rsp_valid = (fcnt_q != '0);
  assign rsp_id    = fid_q[rd_q];
  assign rsp_data  = fdat_q[rd_q];
  assign busy      = (|tag_vld_q) || rsp_valid;

`ifdef MAC_SHARE_STATS_EN
  logic [15:0] gcnt_q [N_REQ];

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) gcnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < N_REQ; i++) gcnt_q[i] <= '0;
    end else if (hs && (gcnt_q[gnt_idx] != 16'hFFFF)) begin
      gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < N_REQ; i++) grant_count[i*16 +: 16] = gcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Scoreboard bench for mac_share_arbiter: cycle model of arbitration/credits plus a response queue.
module tb_mac_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 2;
  localparam int D = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a, req_b, req_c;
  logic [W-1:0]    mac_a, mac_b, mac_c;
  logic [2*W-1:0]  mac_result = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_data;
  logic            busy;
`ifdef MAC_SHARE_STATS_EN
  logic            stats_clr = 1'b0;
  logic [N*16-1:0] grant_count;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t fifo_q[$];
  rsp_t pt[L];
  logic [L-1:0] pv = '0;
  int   m_ptr = 0;
  int   gq[$];
  int   lat;

  mac_share_arbiter #(.bus_width(W), .N_REQ(N), .MAC_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_result(mac_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef MAC_SHARE_STATS_EN
    , .stats_clr(stats_clr), .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  // Shared unit model: result of operands registered at edge E is presented for capture at edge E+L (L=2).
  always @(posedge clk) mac_result <= 16'(mac_a) * 16'(mac_b) + 16'(mac_c);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: predict and check at negedge+1, advance the model at the posedge.
  task automatic step();
    logic         pop;
    int           win;
    int           infl;
    logic [N-1:0] er;
    #1;
    pop  = (fifo_q.size() > 0) && rsp_ready;
    infl = 0;
    for (int s = 0; s < L; s++) if (pv[s]) infl++;
    win = -1;
    if ((infl + fifo_q.size() < D) || pop)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(fifo_q.size() > 0));
    check("busy", 32'(busy), 32'((pv != '0) || (fifo_q.size() > 0)));
    if (pop) begin
      check("rsp_id", 32'(rsp_id), 32'(fifo_q[0].id));
      check("rsp_data", 32'(rsp_data), 32'(fifo_q[0].data));
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
    @(posedge clk);
    if (pop) void'(fifo_q.pop_front());
    if (pv[L-1]) fifo_q.push_back(pt[L-1]);
    for (int s = L - 1; s > 0; s--) begin
      pv[s] = pv[s-1];
      pt[s] = pt[s-1];
    end
    pv[0] = (win >= 0);
    if (win >= 0) begin
      pt[0].id   = 2'(win);
      pt[0].data = 16'(req_a[win*W +: W]) * 16'(req_b[win*W +: W]) + 16'(req_c[win*W +: W]);
      m_ptr      = (win + 1) % N;
    end
    @(negedge clk);
    if (win >= 0) begin
      req_a[win*W +: W] = 8'($urandom);
      req_b[win*W +: W] = 8'($urandom);
      req_c[win*W +: W] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    fifo_q.delete();
    gq.delete();
    pv    = '0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    req_a = $urandom();
    req_b = $urandom();
    req_c = $urandom();
    do_reset();

    // Single issue 3*5+7 and its latency.
    rsp_ready  = 1'b1;
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd5;
    req_c[7:0] = 8'd7;
    req_valid  = 4'b0001;
    step();
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    check("t1_latency", 32'(lat), 32'(L + 1));
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_data", 32'(rsp_data), 32'd22);
    repeat (3) step();

    // All requesters continuously valid: strict rotation.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    repeat (12) step();
    req_valid = '0;
    repeat (6) step();
    check("t2_count", 32'(gq.size()), 32'd12);
    for (int k = 0; k < gq.size() && k < 12; k++) check("t2_order", 32'(gq[k]), 32'(k % N));

    // Backpressure: exactly D issues, resume on the first pop.
    do_reset();
    req_valid = 4'hF;
    repeat (10) step();
    check("t3_issues", 32'(gq.size()), 32'(D));
    rsp_ready = 1'b1;
    #1;
    check("t3_resume", 32'(|req_ready), 32'd1);
    repeat (8) step();
    req_valid = '0;
    repeat (8) step();

    // Wrap search from pointer 2 with only requester 1 valid.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    #1;
    check("t4_wrap", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0110;
    #1;
    check("t4_ptr", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    repeat (6) step();

    // Reset with two in flight and one buffered.
    do_reset();
    req_valid = 4'b0001;
    repeat (3) step();
    req_valid = '0;
    check("t5_busy_pre", 32'(busy), 32'd1);
    check("t5_valid_pre", 32'(rsp_valid), 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    repeat (8) step();

`ifdef MAC_SHARE_STATS_EN
    // Grant counters: 10 grants, then a clear colliding with a grant.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    repeat (10) step();
    check("t6_count", 32'(grant_count[48 +: 16]), 32'd10);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("t6_clear", 32'(grant_count[48 +: 16]), 32'd0);
    req_valid = '0;
    repeat (6) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one fixed-latency multiply-add unit (result = A*B + C) among N_REQ requesters.
- Each requester has a valid/ready operand port.
- Round-robin arbitration selects at most one request per cycle and drives the operands to the shared unit.
- Results are tagged with the requester ID and buffered in a response FIFO with backpressure. Issue is credit-gated so no result is ever dropped.

Parameters:
- bus_width, 8, operand width of A, B and C; result width is 2*bus_width.
- N_REQ, 4, number of requesters (2..8).
- MAC_LATENCY, 2, cycles from operands registered on mac_a/b/c to a valid mac_result (1..4).
- FIFO_DEPTH, 4, response FIFO entries; must be >= MAC_LATENCY.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  request valid, one bit per requester.
- req_ready  output  N_REQ  grant/accept; one-hot or zero.
- req_a  input  N_REQ*bus_width  A operands; requester i occupies bits [i*bus_width +: bus_width], same for B and C.
- req_b  input  N_REQ*bus_width  B operands.
- req_c  input  N_REQ*bus_width  C operands.
- mac_a  output  bus_width  registered A to shared unit.
- mac_b  output  bus_width  registered B to shared unit.
- mac_c  output  bus_width  registered C to shared unit.
- mac_result  input  2*bus_width  shared-unit result.
- rsp_valid  output  1  response available (FIFO not empty).
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  $clog2(N_REQ)  requester index of the head response.
- rsp_data  output  2*bus_width  head result.
- busy  output  1  any operation in flight or any response buffered.

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, mac_a/b/c=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Round-robin pointer=0; in-flight tag pipe cleared; FIFO empty; credits=FIFO_DEPTH.
- Credits:
  - credits = FIFO_DEPTH - (in-flight + FIFO occupancy).
  - Issue is allowed only when credits > 0.
  - A FIFO pop in the same cycle counts, so issue is allowed at credits=0 if rsp_valid&&rsp_ready.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at pointer, wrapping modulo N_REQ; first set bit i wins.
  - req_ready[i]=1 only if issue is allowed; all other bits are 0.
  - Handshake completes when req_valid[i]&&req_ready[i].
- Issue (at the handshake edge):
  - mac_a/b/c <= req_a/b/c slice i.
  - Tag {valid=1, id=i} enters a MAC_LATENCY-deep shift pipe.
  - Pointer <= (i+1) mod N_REQ.
- No handshake:
  - mac_a/b/c hold their previous values; a tag with valid=0 enters the pipe; pointer unchanged.
- Capture:
  - When the pipe output tag is valid, {id, mac_result} is written to the FIFO on that edge.
  - Latency from handshake edge to rsp_valid=1 is MAC_LATENCY+1 cycles when the FIFO is empty.
- Response:
  - rsp_id/rsp_data show the FIFO head; pop on rsp_valid&&rsp_ready.
  - Simultaneous push and pop are both honoured; occupancy is unchanged.
  - Ordering is strict issue order.
- Boundaries:
  - FIFO full and no pop: req_ready=0 for all requesters; at most FIFO_DEPTH results are ever outstanding.
  - A requester holding valid without a grant keeps its operands stable; dropping valid before the grant is allowed.
  - Pointer wraps from N_REQ-1 to 0.
  - Single requester with continuous valid: one issue per cycle while credits allow.
- busy = any valid tag in the pipe || FIFO not empty.
- Reset mid-operation flushes in-flight tags and the FIFO; their results are lost.
- Arithmetic: done by the shared unit; the controller never modifies data widths.

Optional Feature:
- Macro: MAC_SHARE_STATS_EN.
- When defined:
  - Adds output grant_count (N_REQ*16), one counter per requester.
  - Each 16-bit counter saturates at 16'hFFFF and increments on each handshake of its requester.
  - Adds input stats_clr (1); stats_clr=1 zeroes all counters synchronously and wins over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- When undefined: neither port exists and no counters are built. Arbitration and timing are identical either way.

Test Plan:
- Reset, then requester 0 issues A=3, B=5, C=7, rsp_ready=1 -> rsp_valid rises MAC_LATENCY+1 cycles after the handshake; rsp_id=0, rsp_data=22.
- All four requesters valid continuously, different operands -> grant order 0,1,2,3,0,...; responses carry matching IDs in that order, one per cycle.
- rsp_ready=0 with all requesters valid -> exactly FIFO_DEPTH=4 issues, then req_ready=0; raising rsp_ready drains the FIFO and grants resume in the same cycle as the first pop.
- Pointer at 2, only requester 1 valid -> requester 1 is granted (wrap search); pointer becomes 2.
- Assert rst_n=0 with two operations in flight and one buffered -> rsp_valid=0 and busy=0 immediately; no stale response appears after release.
- MAC_SHARE_STATS_EN: 10 grants to requester 3, then stats_clr pulsed in the same cycle as a grant -> grant_count slice 3 reads 10, then 0.
